// File: rtl/risc16_mbist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : risc16_mbist_ctrl
// Purpose  : March C- BIST sequencer/checker for one single-port synchronous SRAM
// Revision : 1.0 - initial release
// ============================================================================
module risc16_mbist_ctrl #(
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 16,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mbist_start,
    output logic              mbist_done,
    output logic              mbist_fail,
    output logic              bist_active,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [2:0]        ELEM_LAST = 3'd5;

    state_t              state_q, state_d;
    logic                start_prev_q;
    logic [2:0]          elem_q, elem_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                phase_q, phase_d;

    // Pin stage: the access currently presented to the memory
    logic                cs_q, cs_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   maddr_q, maddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   pexp_q, pexp_d;
    logic [2:0]          pelem_q, pelem_d;

    // Compare stage: aligned with mem_rdata of the previous cycle's read
    logic                cmp_vld_q, cmp_vld_d;
    logic [DATA_W-1:0]   cmp_exp_q, cmp_exp_d;
    logic [ADDR_W-1:0]   cmp_addr_q, cmp_addr_d;
    logic [2:0]          cmp_elem_q, cmp_elem_d;

    logic                done_q, done_d;
    logic                fail_q, fail_d;
    logic [ADDR_W-1:0]   faddr_q, faddr_d;
    logic [2:0]          felem_q, felem_d;
    logic                active_q, active_d;

    logic                accept;
    logic                mismatch;
    logic                stop;
    logic                elem_rw;
    logic                elem_down;
    logic                addr_term;
    logic                last_rd;
    logic                issue;
    logic [2:0]          elem_nxt;
    logic [DATA_W-1:0]   rd_word;

    assign accept    = (state_q == S_IDLE) && mbist_start && !start_prev_q;
    assign mismatch  = cmp_vld_q && (mem_rdata != cmp_exp_q);
    assign stop      = (STOP_ON_FAIL != 0) && mismatch;
    assign elem_rw   = (elem_q >= 3'd1) && (elem_q <= 3'd4);
    assign elem_down = (elem_q == 3'd3) || (elem_q == 3'd4);
    assign rd_word   = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
    assign addr_term = elem_down ? (addr_q == '0) : (addr_q == ADDR_LAST);
    assign elem_nxt  = elem_q + 3'd1;
    assign issue     = (elem_q <= ELEM_LAST);
    assign last_rd   = cs_q && !we_q && (pelem_q == ELEM_LAST) && (maddr_q == ADDR_LAST);

    always_comb begin
        state_d    = state_q;
        elem_d     = elem_q;
        addr_d     = addr_q;
        phase_d    = phase_q;
        cs_d       = 1'b0;
        we_d       = 1'b0;
        maddr_d    = maddr_q;
        wdata_d    = wdata_q;
        pexp_d     = pexp_q;
        pelem_d    = pelem_q;
        cmp_vld_d  = cs_q && !we_q;
        cmp_exp_d  = pexp_q;
        cmp_addr_d = maddr_q;
        cmp_elem_d = pelem_q;
        done_d     = done_q;
        fail_d     = fail_q;
        faddr_d    = faddr_q;
        felem_d    = felem_q;
        active_d   = active_q;

        if ((state_q != S_IDLE) && mismatch) begin
            fail_d = 1'b1;
            if (!fail_q) begin
                faddr_d = cmp_addr_q;
                felem_d = cmp_elem_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d  = S_RUN;
                    done_d   = 1'b0;
                    fail_d   = 1'b0;
                    faddr_d  = '0;
                    felem_d  = 3'd0;
                    active_d = 1'b1;
                    elem_d   = 3'd0;
                    addr_d   = '0;
                    phase_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    active_d  = 1'b0;
                    cmp_vld_d = 1'b0;
                end else begin
                    if (issue) begin
                        cs_d    = 1'b1;
                        we_d    = (elem_q == 3'd0) || phase_q;
                        maddr_d = addr_q;
                        wdata_d = (elem_q == 3'd0) ? {DATA_W{1'b0}} : ~rd_word;
                        pexp_d  = rd_word;
                        pelem_d = elem_q;
                        if (elem_rw && !phase_q) begin
                            phase_d = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            if (addr_term) begin
                                // Descending elements E3/E4 begin at the top address
                                elem_d = elem_nxt;
                                addr_d = ((elem_nxt == 3'd3) || (elem_nxt == 3'd4)) ? ADDR_LAST : '0;
                            end else begin
                                addr_d = elem_down ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
                            end
                        end
                    end
                    if (last_rd) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                state_d   = S_IDLE;
                done_d    = 1'b1;
                active_d  = 1'b0;
                cmp_vld_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            // A start level already high when reset releases is not an edge
            start_prev_q <= 1'b1;
            elem_q       <= 3'd0;
            addr_q       <= '0;
            phase_q      <= 1'b0;
            cs_q         <= 1'b0;
            we_q         <= 1'b0;
            maddr_q      <= '0;
            wdata_q      <= '0;
            pexp_q       <= '0;
            pelem_q      <= 3'd0;
            cmp_vld_q    <= 1'b0;
            cmp_exp_q    <= '0;
            cmp_addr_q   <= '0;
            cmp_elem_q   <= 3'd0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            faddr_q      <= '0;
            felem_q      <= 3'd0;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= mbist_start;
            elem_q       <= elem_d;
            addr_q       <= addr_d;
            phase_q      <= phase_d;
            cs_q         <= cs_d;
            we_q         <= we_d;
            maddr_q      <= maddr_d;
            wdata_q      <= wdata_d;
            pexp_q       <= pexp_d;
            pelem_q      <= pelem_d;
            cmp_vld_q    <= cmp_vld_d;
            cmp_exp_q    <= cmp_exp_d;
            cmp_addr_q   <= cmp_addr_d;
            cmp_elem_q   <= cmp_elem_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            faddr_q      <= faddr_d;
            felem_q      <= felem_d;
            active_q     <= active_d;
        end
    end

    assign mbist_done  = done_q;
    assign mbist_fail  = fail_q;
    assign bist_active = active_q;
    assign mem_cs      = cs_q;
    assign mem_we      = we_q;
    assign mem_addr    = maddr_q;
    assign mem_wdata   = wdata_q;
    assign fail_addr   = faddr_q;
    assign fail_elem   = felem_q;

endmodule
`default_nettype wire

// File: tb/tb_risc16_mbist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_risc16_mbist_ctrl
// Purpose  : Scoreboard bench for the March C- BIST controller (N=4 words)
// Revision : 1.0 - initial release
// ============================================================================
module tb_risc16_mbist_ctrl;

    localparam int AW = 2;
    localparam int DW = 16;
    localparam int N  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_n, start_s;
    logic          fault_sa = 1'b0;
    logic          fault_cp = 1'b0;

    logic          done_n, fail_n, act_n, cs_n, we_n;
    logic [AW-1:0] addr_n, faddr_n;
    logic [DW-1:0] wdata_n, rdata_n;
    logic [2:0]    felem_n;

    logic          done_s, fail_s, act_s, cs_s, we_s;
    logic [AW-1:0] addr_s, faddr_s;
    logic [DW-1:0] wdata_s, rdata_s;
    logic [2:0]    felem_s;

    logic [DW-1:0] mem_n [N];
    logic [DW-1:0] mem_s [N];

    logic [31:0]   q_n [$];
    logic [31:0]   q_s [$];

    int            n_chk  = 0;
    int            n_pass = 0;
    int            lat;

    always #5 clk = ~clk;

    risc16_mbist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .STOP_ON_FAIL(0)) u_dut_n (
        .clk(clk), .rst_n(rst_n), .mbist_start(start_n),
        .mbist_done(done_n), .mbist_fail(fail_n), .bist_active(act_n),
        .mem_cs(cs_n), .mem_we(we_n), .mem_addr(addr_n), .mem_wdata(wdata_n),
        .mem_rdata(rdata_n), .fail_addr(faddr_n), .fail_elem(felem_n)
    );

    risc16_mbist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .STOP_ON_FAIL(1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .mbist_start(start_s),
        .mbist_done(done_s), .mbist_fail(fail_s), .bist_active(act_s),
        .mem_cs(cs_s), .mem_we(we_s), .mem_addr(addr_s), .mem_wdata(wdata_s),
        .mem_rdata(rdata_s), .fail_addr(faddr_s), .fail_elem(felem_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] pack(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        return {13'd0, we, a, (we ? d : 16'h0000)};
    endfunction

    // Sync SRAM models: bit 3 of word 2 can read stuck-at-1; writing ones to word 1 can flip word 0
    always @(posedge clk) begin
        if (cs_n === 1'b1) begin
            if (we_n) begin
                mem_n[addr_n] <= wdata_n;
                if (fault_cp && addr_n == 2'd1 && wdata_n == 16'hFFFF) mem_n[0] <= ~mem_n[0];
            end else begin
                rdata_n <= mem_n[addr_n] | ((fault_sa && addr_n == 2'd2) ? 16'h0008 : 16'h0000);
            end
        end
    end

    always @(posedge clk) begin
        if (cs_s === 1'b1) begin
            if (we_s) begin
                mem_s[addr_s] <= wdata_s;
                if (fault_cp && addr_s == 2'd1 && wdata_s == 16'hFFFF) mem_s[0] <= ~mem_s[0];
            end else begin
                rdata_s <= mem_s[addr_s] | ((fault_sa && addr_s == 2'd2) ? 16'h0008 : 16'h0000);
            end
        end
    end

    always @(negedge clk) begin
        if (cs_n === 1'b1) begin
            if (q_n.size() == 0) chk("acc_n_extra", 32'd1, 32'd0);
            else chk("acc_n", pack(we_n, addr_n, wdata_n), q_n.pop_front());
        end
    end

    always @(negedge clk) begin
        if (cs_s === 1'b1) begin
            if (q_s.size() == 0) chk("acc_s_extra", 32'd1, 32'd0);
            else chk("acc_s", pack(we_s, addr_s, wdata_s), q_s.pop_front());
        end
    end

    task automatic put(input bit sel, input logic [31:0] v);
        if (sel) q_s.push_back(v);
        else q_n.push_back(v);
    endtask

    // Expected March C- access order, truncated to the first 'limit' accesses
    task automatic push_seq(input bit sel, input int limit);
        int cnt;
        int a;
        logic [DW-1:0] v;
        cnt = 0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < N; i++) begin
                a = (e == 3 || e == 4) ? (N - 1 - i) : i;
                v = (e == 2 || e == 4) ? 16'hFFFF : 16'h0000;
                if (e == 0) begin
                    if (cnt < limit) put(sel, pack(1'b1, a[AW-1:0], 16'h0000));
                    cnt++;
                end else begin
                    if (cnt < limit) put(sel, pack(1'b0, a[AW-1:0], 16'h0000));
                    cnt++;
                    if (e <= 4) begin
                        if (cnt < limit) put(sel, pack(1'b1, a[AW-1:0], ~v));
                        cnt++;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit sel, input int budget, output int l);
        l = budget + 1;
        for (int e = 1; e <= budget; e++) begin
            @(posedge clk);
            #1;
            if ((sel ? done_s : done_n) === 1'b1) begin
                l = e;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        start_n = 1'b0;
        start_s = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs_n", {24'd0, done_n, fail_n, act_n, cs_n, we_n, felem_n}, 32'd0);
        chk("rst_addr_n", {addr_n, faddr_n, wdata_n}, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_after_rst", {done_n, act_n, cs_n, done_s, act_s, cs_s}, 32'd0);

        // Fault-free run with a single-cycle start pulse
        push_seq(1'b0, 40);
        start_n = 1'b1;
        tick();
        chk("t1_active", act_n, 1);
        chk("t1_done_clr", done_n, 0);
        start_n = 1'b0;
        wait_done(1'b0, 60, lat);
        chk("t1_latency", lat, 42);
        chk("t1_fail", fail_n, 0);
        chk("t1_active_end", act_n, 0);
        chk("t1_q_empty", q_n.size(), 0);
        repeat (5) tick();
        chk("t1_done_sticky", {done_n, act_n}, 32'd2);

        // Stuck-at fault, start held high through and after the run
        fault_sa = 1'b1;
        push_seq(1'b0, 40);
        start_n = 1'b1;
        tick();
        chk("t2_fail_clr", fail_n, 0);
        wait_done(1'b0, 60, lat);
        chk("t2_latency", lat, 42);
        chk("t2_fail", fail_n, 1);
        chk("t2_faddr", faddr_n, 2);
        chk("t2_felem", felem_n, 1);
        chk("t2_q_empty", q_n.size(), 0);
        repeat (20) tick();
        chk("t4_no_rerun", {done_n, act_n, fail_n}, 32'd5);

        // Re-arm by dropping start for one cycle; clean memory this time
        start_n = 1'b0;
        tick();
        fault_sa = 1'b0;
        push_seq(1'b0, 40);
        start_n = 1'b1;
        tick();
        chk("t4_accept_clr", {done_n, fail_n, act_n}, 32'd1);
        chk("t4_fail_loc_clr", {faddr_n, felem_n}, 32'd0);
        start_n = 1'b0;
        wait_done(1'b0, 60, lat);
        chk("t4_latency", lat, 42);
        chk("t4_fail", fail_n, 0);

        // Asynchronous reset in the middle of E3
        push_seq(1'b0, 40);
        start_n = 1'b1;
        tick();
        start_n = 1'b0;
        repeat (24) tick();
        chk("t5_mid_run", {act_n, cs_n}, 32'd3);
        start_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        q_n.delete();
        chk("t5_async_outs", {24'd0, done_n, fail_n, act_n, cs_n, we_n, felem_n}, 32'd0);
        chk("t5_async_addr", {addr_n, faddr_n, wdata_n}, 32'd0);
        #3;
        rst_n = 1'b1;
        repeat (10) tick();
        chk("t5_stay_idle", {done_n, act_n, cs_n}, 32'd0);
        start_n = 1'b0;
        tick();

        // Coupling fault: ones written to word 1 invert word 0
        fault_cp = 1'b1;
        push_seq(1'b0, 40);
        start_n = 1'b1;
        tick();
        start_n = 1'b0;
        wait_done(1'b0, 60, lat);
        chk("t6_latency", lat, 42);
        chk("t6_fail", fail_n, 1);
        chk("t6_faddr", faddr_n, 0);
        chk("t6_felem", felem_n, 2);
        chk("t6_q_empty", q_n.size(), 0);
        fault_cp = 1'b0;

        // Stop-on-fail instance with the stuck-at fault
        fault_sa = 1'b1;
        push_seq(1'b1, 10);
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        wait_done(1'b1, 60, lat);
        chk("t3_latency", lat, 11);
        chk("t3_fail", fail_s, 1);
        chk("t3_faddr", faddr_s, 2);
        chk("t3_felem", felem_s, 1);
        chk("t3_active", act_s, 0);
        repeat (8) tick();
        chk("t3_q_empty", q_s.size(), 0);
        chk("t3_cs_low", cs_s, 0);
        fault_sa = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
